// File: rtl/fto_sweep_ctrl_if.sv
// Signal bundle between fto_sweep_ctrl and its host/fto block: handshake, results and fto drive.
// With FTO_SWEEP_CHECK_EN defined the bundle also carries expected/mismatch/fail_index.
interface fto_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic [4:0]  ones_count;
  logic        fto_out;
  logic        fto_a;
  logic        fto_b;
  logic        fto_c;
  logic        fto_d;
`ifdef FTO_SWEEP_CHECK_EN
  logic [15:0] expected;
  logic        mismatch;
  logic [3:0]  fail_index;

  modport master (
    output start, abort, fto_out, expected,
    input  busy, done, truth_table, ones_count, fto_a, fto_b, fto_c, fto_d,
           mismatch, fail_index
  );

  modport slave (
    input  start, abort, fto_out, expected,
    output busy, done, truth_table, ones_count, fto_a, fto_b, fto_c, fto_d,
           mismatch, fail_index
  );
`else
  modport master (
    output start, abort, fto_out,
    input  busy, done, truth_table, ones_count, fto_a, fto_b, fto_c, fto_d
  );

  modport slave (
    input  start, abort, fto_out,
    output busy, done, truth_table, ones_count, fto_a, fto_b, fto_c, fto_d
  );
`endif
endinterface

// File: rtl/fto_sweep_ctrl.sv
// Walks fto through all 16 input vectors, holding each SETTLE_CYCLES+1 cycles, and records its truth table.
// Optional FTO_SWEEP_CHECK_EN compares each capture against a latched expected table.
module fto_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  fto_sweep_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] IDX_LAST    = 4'd15;

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("fto_sweep_ctrl: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  state_t      state;
  state_t      next_state;
  logic [3:0]  idx;
  logic [3:0]  settle_cnt;
  logic [15:0] truth_table;
  logic [4:0]  ones_count;
  logic        busy;
  logic        done;
  logic [3:0]  drive;

  logic        start_accept;
  logic        last_settle;
  logic        last_idx;
  logic        capture_en;

  assign start_accept = (state == IDLE) && bus.start;
  assign last_settle  = (settle_cnt == SETTLE_LAST);
  assign last_idx     = (idx == IDX_LAST);
  // abort takes priority over the sample taken in the same cycle
  assign capture_en   = (state == CAPTURE) && !bus.abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          next_state = IDLE;
        end else if (last_settle) begin
          next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.abort) begin
          next_state = IDLE;
        end else if (last_idx) begin
          next_state = FINISH;
        end else begin
          next_state = SETTLE;
        end
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    drive = 4'd0;
    case (state)
      SETTLE, CAPTURE: begin
        busy  = 1'b1;
        drive = idx;
      end
      FINISH: begin
        done = 1'b1;
      end
      default: begin
        busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= 4'd0;
      settle_cnt  <= 4'd0;
      truth_table <= 16'd0;
      ones_count  <= 5'd0;
    end else if (start_accept) begin
      idx         <= 4'd0;
      settle_cnt  <= 4'd0;
      truth_table <= 16'd0;
      ones_count  <= 5'd0;
    end else if (state == SETTLE) begin
      if (!bus.abort && !last_settle) begin
        settle_cnt <= settle_cnt + 4'd1;
      end
    end else if (capture_en) begin
      truth_table[idx] <= bus.fto_out;
      ones_count       <= ones_count + {4'd0, bus.fto_out};
      settle_cnt       <= 4'd0;
      if (!last_idx) begin
        idx <= idx + 4'd1;
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.truth_table = truth_table;
  assign bus.ones_count  = ones_count;
  assign bus.fto_a       = drive[3];
  assign bus.fto_b       = drive[2];
  assign bus.fto_c       = drive[1];
  assign bus.fto_d       = drive[0];

`ifdef FTO_SWEEP_CHECK_EN
  logic [15:0] expected_latched;
  logic        mismatch;
  logic [3:0]  fail_index;

  // Only the first disagreeing index is recorded; the sweep itself is never cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected_latched <= 16'd0;
      mismatch         <= 1'b0;
      fail_index       <= 4'd0;
    end else if (start_accept) begin
      expected_latched <= bus.expected;
      mismatch         <= 1'b0;
      fail_index       <= 4'd0;
    end else if (capture_en && !mismatch && (bus.fto_out != expected_latched[idx])) begin
      mismatch   <= 1'b1;
      fail_index <= idx;
    end
  end

  assign bus.mismatch   = mismatch;
  assign bus.fail_index = fail_index;
`endif

  a_done_single: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));
  a_ones_range: assert property (@(posedge clk) disable iff (!rst_n) ones_count <= 5'd16);

endmodule

// File: tb/tb_fto_sweep_ctrl.sv
// Scoreboard bench for fto_sweep_ctrl; models fto in software and checks timing, tables and abort/reset handling.
// Define FTO_SWEEP_CHECK_EN to also exercise the expected-table checker.
module tb_fto_sweep_ctrl;

  localparam int SETTLE = 2;
  localparam int HOLD   = SETTLE + 1;
  localparam int ACTIVE = 16 * HOLD;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  oc;
    logic        mm;
    logic [3:0]  fi;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   mode;
  int   assertCount = 0;
  int   failCount   = 0;
  exp_t sbq[$];

  fto_sweep_ctrl_if bus();

  fto_sweep_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // mode 0: A^D, mode 1: A&B&C&D, mode 2: A^D with index 10 forced to 0
  function automatic logic ftoModel(int m, logic [3:0] v);
    case (m)
      1:       return &v;
      2:       return (v == 4'd10) ? 1'b0 : (v[3] ^ v[0]);
      default: return v[3] ^ v[0];
    endcase
  endfunction

  always_comb bus.fto_out = ftoModel(mode, {bus.fto_a, bus.fto_b, bus.fto_c, bus.fto_d});

  task automatic checkOutput(string tag, logic [31:0] actual, logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic exp_t buildExpected(int m, int nCap, logic [15:0] expVec);
    exp_t e;
    e.tt = 16'd0;
    e.oc = 5'd0;
    e.mm = 1'b0;
    e.fi = 4'd0;
    for (int i = 0; i < nCap; i++) begin
      logic b;
      b = ftoModel(m, 4'(i));
      e.tt[i] = b;
      e.oc = e.oc + 5'(b);
      if (!e.mm && (b != expVec[i])) begin
        e.mm = 1'b1;
        e.fi = 4'(i);
      end
    end
    return e;
  endfunction

  // Pops one expected result for every done pulse the DUT produces
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
        if (sbq.size() == 0) begin
          checkOutput("sb_spurious_done", 32'(bus.done), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("sb_truth_table", 32'(bus.truth_table), 32'(e.tt));
          checkOutput("sb_ones_count", 32'(bus.ones_count), 32'(e.oc));
`ifdef FTO_SWEEP_CHECK_EN
          checkOutput("sb_mismatch", 32'(bus.mismatch), 32'(e.mm));
          checkOutput("sb_fail_index", 32'(bus.fail_index), 32'(e.fi));
`endif
        end
      end
    end
  end

  task automatic applyStimulus(int m, int abortCycle, bit restartMid, bit startWithAbort,
                               logic [15:0] expVec);
    exp_t e;
    int   nCap;
    int   lastK;
    bit   aborted;
    bit   expBusy;
    bit   expDone;
    int   expIdx;
    mode = m;
    nCap = (abortCycle == 0) ? 16 : (abortCycle - 1) / HOLD;
    e    = buildExpected(m, nCap, expVec);
`ifdef FTO_SWEEP_CHECK_EN
    bus.expected = expVec;
`endif
    if (abortCycle == 0) sbq.push_back(e);
    lastK     = (abortCycle == 0) ? ACTIVE + 3 : abortCycle + 4;
    bus.start = 1'b1;
    bus.abort = startWithAbort;
    for (int k = 1; k <= lastK; k++) begin
      @(posedge clk);
      #1;
      aborted = (abortCycle != 0) && (k > abortCycle);
      expBusy = !aborted && (k <= ACTIVE);
      expDone = !aborted && (k == ACTIVE + 1);
      expIdx  = expBusy ? (k - 1) / HOLD : 0;
      checkOutput($sformatf("busy@%0d", k), 32'(bus.busy), 32'(expBusy));
      checkOutput($sformatf("done@%0d", k), 32'(bus.done), 32'(expDone));
      checkOutput($sformatf("vector@%0d", k),
                  32'({bus.fto_a, bus.fto_b, bus.fto_c, bus.fto_d}), 32'(expIdx));
      bus.start = restartMid && (k == 20 || k == ACTIVE + 1);
      bus.abort = (k == abortCycle);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("held_truth_table", 32'(bus.truth_table), 32'(e.tt));
    checkOutput("held_ones_count", 32'(bus.ones_count), 32'(e.oc));
    checkOutput("sb_empty", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic resetMidSweep();
    exp_t e;
    mode = 0;
    e    = buildExpected(0, 8, 16'h55AA);
    bus.start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    checkOutput("pre_reset_busy", 32'(bus.busy), 32'd1);
    checkOutput("pre_reset_table", 32'(bus.truth_table), 32'(e.tt));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_table", 32'(bus.truth_table), 32'd0);
    checkOutput("rst_ones", 32'(bus.ones_count), 32'd0);
    checkOutput("rst_vector", 32'({bus.fto_a, bus.fto_b, bus.fto_c, bus.fto_d}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("post_reset_busy@%0d", k), 32'(bus.busy), 32'd0);
      checkOutput($sformatf("post_reset_done@%0d", k), 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    mode      = 0;
`ifdef FTO_SWEEP_CHECK_EN
    bus.expected = 16'd0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_table", 32'(bus.truth_table), 32'd0);
    checkOutput("reset_ones", 32'(bus.ones_count), 32'd0);
    checkOutput("reset_vector", 32'({bus.fto_a, bus.fto_b, bus.fto_c, bus.fto_d}), 32'd0);
`ifdef FTO_SWEEP_CHECK_EN
    checkOutput("reset_mismatch", 32'(bus.mismatch), 32'd0);
    checkOutput("reset_fail_index", 32'(bus.fail_index), 32'd0);
`endif

    $display("[TB] sweep with fto = A^D");
    applyStimulus(0, 0, 1'b0, 1'b0, 16'h55AA);
    checkOutput("xor_table", 32'(bus.truth_table), 32'h55AA);
    checkOutput("xor_ones", 32'(bus.ones_count), 32'd8);

    $display("[TB] two sweeps with fto = A&B&C&D");
    applyStimulus(1, 0, 1'b0, 1'b0, 16'h8000);
    checkOutput("and_table", 32'(bus.truth_table), 32'h8000);
    checkOutput("and_ones", 32'(bus.ones_count), 32'd1);
    applyStimulus(1, 0, 1'b0, 1'b0, 16'h8000);
    checkOutput("and_table_again", 32'(bus.truth_table), 32'h8000);
    checkOutput("and_ones_again", 32'(bus.ones_count), 32'd1);

    $display("[TB] abort in SETTLE of index 5");
    applyStimulus(0, 5 * HOLD + 1, 1'b0, 1'b0, 16'h55AA);
    checkOutput("abort_settle_table", 32'(bus.truth_table), 32'h000A);
    checkOutput("abort_settle_ones", 32'(bus.ones_count), 32'd2);

    $display("[TB] abort coincident with CAPTURE of index 5");
    applyStimulus(0, 6 * HOLD, 1'b0, 1'b0, 16'h55AA);
    checkOutput("abort_capture_table", 32'(bus.truth_table), 32'h000A);
    checkOutput("abort_capture_ones", 32'(bus.ones_count), 32'd2);

    $display("[TB] start with abort, restarts mid-sweep and in FINISH");
    applyStimulus(0, 0, 1'b1, 1'b1, 16'h55AA);
    checkOutput("restart_table", 32'(bus.truth_table), 32'h55AA);

    $display("[TB] reset mid-sweep");
    resetMidSweep();

`ifdef FTO_SWEEP_CHECK_EN
    $display("[TB] checker sweep with fault at index 10");
    applyStimulus(2, 0, 1'b0, 1'b0, 16'h55AA);
    checkOutput("chk_mismatch", 32'(bus.mismatch), 32'd1);
    checkOutput("chk_fail_index", 32'(bus.fail_index), 32'd10);
    checkOutput("chk_table", 32'(bus.truth_table), 32'h51AA);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fto_sweep_ctrl.md
Name: fto_sweep_ctrl

Overview:
Sequencer that exhaustively drives the 4-input combinational function block fto (inputs A,B,C,D; output out) through all 16 input combinations in ascending order. It captures each result into a 16-bit truth-table register. It replaces hand-written stimulus sweeps with an on-chip characterisation/self-test controller that sits beside fto and owns its inputs. It uses a start/busy/done handshake and supports abort.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling fto out. Legal range 1..15; values outside this range are illegal (elaboration error is acceptable).

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  sweep request, sampled in IDLE only
abort  input  1  cancel sweep in progress
fto_out  input  1  result from fto block
fto_a  output  1  drive for fto A (index bit 3)
fto_b  output  1  drive for fto B (index bit 2)
fto_c  output  1  drive for fto C (index bit 1)
fto_d  output  1  drive for fto D (index bit 0)
busy  output  1  high in SETTLE and CAPTURE
done  output  1  one-cycle pulse, sweep completed
truth_table  output  16  bit i = fto_out captured for index i = {A,B,C,D}
ones_count  output  5  number of captured 1s, range 0..16

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; idx=0, settle_cnt=0; all outputs 0, including truth_table and ones_count.
- FSM states: IDLE, SETTLE, CAPTURE, FINISH.
- IDLE:
  - busy=0; fto_a..d=0.
  - start=1 -> clear truth_table and ones_count, idx<=0, settle_cnt<=0, go to SETTLE.
- SETTLE:
  - busy=1; {fto_a,fto_b,fto_c,fto_d}=idx.
  - If settle_cnt==SETTLE_CYCLES-1 -> go to CAPTURE; otherwise settle_cnt++.
- CAPTURE:
  - busy=1; inputs still driven from idx.
  - truth_table[idx]<=fto_out; ones_count<=ones_count+fto_out.
  - If idx==15 -> go to FINISH; otherwise idx++, settle_cnt<=0, go to SETTLE.
- FINISH: done=1 for exactly this cycle; busy=0; fto_a..d=0; go to IDLE.
- Latency:
  - Each vector is held SETTLE_CYCLES+1 cycles.
  - With the default SETTLE_CYCLES=2: done is high in the 49th cycle after the start edge (16*3 active cycles, then FINISH).
- Index wrap: idx is 4 bits and never wraps in operation; the terminal test is idx==15.
- start while busy or in FINISH: ignored; no restart and no queuing.
- abort in SETTLE or CAPTURE:
  - Next state is IDLE and done is not pulsed.
  - truth_table and ones_count hold the partial results captured so far.
  - abort wins over a simultaneous capture: that cycle's sample is discarded.
- abort in IDLE or FINISH: no effect.
- start and abort high together in IDLE: start is accepted (abort has no effect in IDLE).
- Reset mid-sweep: immediate return to the reset values; no done pulse.
- truth_table and ones_count are stable from FINISH until the next accepted start.

Optional Feature:
Macro FTO_SWEEP_CHECK_EN.
- Defined:
  - Adds input expected[15:0], latched when start is accepted.
  - Adds output mismatch (1 bit) and output fail_index[3:0], both cleared on accepted start and on reset.
  - In CAPTURE, if fto_out != expected_latched[idx] and mismatch is 0: mismatch<=1, fail_index<=idx. The first failure is kept.
  - The sweep always runs to completion.
- Undefined: these ports and this logic are absent; all other behaviour is identical.

Test Plan:
1. Reset then idle: hold rst_n=0 for 3 cycles, release -> all outputs 0, busy=0, done=0.
2. Full sweep, bench models fto as A^D, start pulsed 1 cycle -> busy high 48 cycles; inputs step 0000..1111, each held 3 cycles; done pulse in cycle 49; truth_table=16'h55AA; ones_count=8.
3. Full sweep, bench models fto as A&B&C&D -> truth_table=16'h8000, ones_count=1. Then a second start gives identical results (registers cleared on start).
4. Abort after vector index 4 is captured (in SETTLE of index 5) -> IDLE next cycle, no done, truth_table bits 0..4 valid and the rest 0. Abort coincident with CAPTURE of index 5 -> bit 5 not written.
5. start re-pulsed mid-sweep and in the FINISH cycle -> ignored; sweep timing unchanged, single done pulse. Assert rst_n low mid-sweep -> outputs 0 immediately.
6. (FTO_SWEEP_CHECK_EN) expected=16'h55AA, fto modelled as A^D but forced to 0 at index 10 -> mismatch=1, fail_index=10, done still pulses in cycle 49.
